cache_refill_arbiter: RTL
=========================

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, word-address width of masters and memory port.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter BLOCK_WIDTH, default 2, log2 of words per cache block; BLOCKS = 2**BLOCK_WIDTH.
REQ-004 i_clock  input  1  single clock; all state changes on rising edge.
REQ-005 i_reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of i_clock).
REQ-006 i_m0_req  input  1  refill request, master 0 (instruction cache).
REQ-007 i_m0_addr  input  ADDR_WIDTH  master 0 word address inside the block to refill.
REQ-008 o_m0_data  output  DATA_WIDTH  refill data to master 0.
REQ-009 o_m0_valid  output  1  o_m0_data valid this cycle (one beat).
REQ-010 o_m0_beat  output  BLOCK_WIDTH  word offset of the current master 0 beat.
REQ-011 o_m0_done  output  1  one-cycle pulse; master 0 burst complete.
REQ-012 i_m1_req, i_m1_addr, o_m1_data, o_m1_valid, o_m1_beat, o_m1_done  same directions/widths/meanings for master 1 (data cache).
REQ-013 o_mem_rd  output  1  memory read request.
REQ-014 o_mem_addr  output  ADDR_WIDTH  memory word address.
REQ-015 i_mem_data  input  DATA_WIDTH  memory read data.
REQ-016 i_mem_ready  input  1  memory beat accepted; i_mem_data valid this cycle.
REQ-017 o_busy  output  1  burst in progress (state BURST or DONE).
REQ-018 o_owner  output  1  index of the master owning the port; valid while o_busy=1.

Function
REQ-019 FSM states IDLE, BURST, DONE; reset state IDLE.
REQ-020 IDLE: if any i_mX_req=1, next state BURST; owner and base address latched that edge; base = i_mX_addr with low BLOCK_WIDTH bits forced to 0; beat counter := 0.
REQ-021 Arbitration: single requester wins; both requesting -> grant master other than last-served; last-served reset value = 1 (master 0 wins first tie).
REQ-022 Grant latency: request sampled in IDLE at edge k -> o_mem_rd=1 from cycle after edge k; no combinational req->o_mem_rd path.
REQ-023 BURST: o_mem_rd=1; o_mem_addr = base | beat counter (beat in low BLOCK_WIDTH bits).
REQ-024 BURST: o_mX_valid (owner only) = i_mem_ready, combinational; o_mX_data = i_mem_data for both masters; o_mX_beat = beat counter for both masters.
REQ-025 Beat counter increments by 1 per cycle with i_mem_ready=1 in BURST; i_mem_ready=0 holds counter and address (wait states unlimited).
REQ-026 Beat with counter = BLOCKS-1 and i_mem_ready=1 -> next state DONE; counter wraps to 0; last-served := owner.
REQ-027 DONE: exactly one cycle; o_mX_done=1 for owner only; o_mem_rd=0; next state IDLE unconditionally; requests ignored in DONE.
REQ-028 Masters drop i_mX_req in the cycle o_mX_done=1; a request still high in IDLE is a new request.
REQ-029 Owner deasserting i_mX_req during BURST is ignored; burst runs to completion and done pulses.
REQ-030 Non-owner request during BURST is held pending, not lost; served next IDLE per REQ-021.
REQ-031 Outside BURST: o_mem_rd=0, all o_mX_valid=0; outside DONE: all o_mX_done=0.
REQ-032 o_busy=1 in BURST and DONE, else 0; o_owner = latched owner, 0 after reset.
REQ-033 Minimum gap between consecutive bursts: one DONE cycle plus one IDLE cycle.
REQ-034 i_mem_ready outside BURST is ignored.

Reset
REQ-035 i_reset=0 at a rising edge: state IDLE, beat counter 0, base 0, owner 0, last-served 1.
REQ-036 Outputs during and after reset until first grant: o_mem_rd=0, o_mem_addr=0, o_mX_valid=0, o_mX_done=0, o_mX_beat=0, o_busy=0, o_owner=0; o_mX_data = i_mem_data.
REQ-037 Reset mid-burst aborts with no done pulse; masters re-request after reset release.

Verification
REQ-038 Only m0_req=1, addr=0x107, mem_ready always 1, BLOCK_WIDTH=2 -> mem_addr 0x104,0x105,0x106,0x107 on 4 consecutive cycles, 4 m0_valid, one m0_done, busy high 5 cycles.
REQ-039 m0_req and m1_req both 1 from reset -> m0 served first, m1 served after DONE+IDLE, then m0 again if still requesting (alternation).
REQ-040 mem_ready pattern 1,0,0,1,1,0,1 -> address held on 0 cycles, exactly 4 valid beats with beats 0..3, done one cycle after last beat.
REQ-041 m1 drops req mid-burst -> burst completes, m1_done pulses; m0 request arriving mid-burst granted after.
REQ-042 i_reset=0 asserted on beat 2 -> next cycle mem_rd=0, busy=0, no done; after release first tie granted to m0.
REQ-043 mem_ready=1 while IDLE with no requests -> no valid, no state change.

Source files
------------

// File: rtl/cache_refill_arbiter.sv
// Two-master cache refill arbiter: grants one master at a time a fixed-length
// burst of BLOCKS word reads on a shared memory port, alternating on ties.
module cache_refill_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_m0_req,
  input  logic [ADDR_WIDTH-1:0]  i_m0_addr,
  output logic [DATA_WIDTH-1:0]  o_m0_data,
  output logic                   o_m0_valid,
  output logic [BLOCK_WIDTH-1:0] o_m0_beat,
  output logic                   o_m0_done,
  input  logic                   i_m1_req,
  input  logic [ADDR_WIDTH-1:0]  i_m1_addr,
  output logic [DATA_WIDTH-1:0]  o_m1_data,
  output logic                   o_m1_valid,
  output logic [BLOCK_WIDTH-1:0] o_m1_beat,
  output logic                   o_m1_done,
  output logic                   o_mem_rd,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  input  logic                   i_mem_ready,
  output logic                   o_busy,
  output logic                   o_owner
);

  localparam int unsigned BLOCKS = 2 ** BLOCK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BlockMask = ADDR_WIDTH'(BLOCKS - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [BLOCK_WIDTH-1:0] beat_q, beat_d;
  logic [1:0]             pend_q, pend_d;

  logic [1:0]             req_vec;
  logic [1:0]             req_eff;
  logic                   grant;
  logic [ADDR_WIDTH-1:0]  grant_addr;

  assign req_vec = {i_m1_req, i_m0_req};
  // Non-owner requests seen mid-burst are remembered so a short pulse is not lost.
  assign req_eff = req_vec | pend_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      base_q  <= '0;
      beat_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    base_d     = base_q;
    beat_d     = beat_q;
    pend_d     = pend_q;
    grant      = 1'b0;
    grant_addr = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_eff) begin
          // On a tie the master that was not served last wins.
          grant        = (&req_eff) ? ~last_q : req_eff[1];
          grant_addr   = grant ? i_m1_addr : i_m0_addr;
          state_d      = StBurst;
          owner_d      = grant;
          base_d       = grant_addr & ~BlockMask;
          beat_d       = '0;
          pend_d[grant] = 1'b0;
        end
      end
      StBurst: begin
        pend_d[~owner_q] = pend_q[~owner_q] | req_vec[~owner_q];
        if (i_mem_ready) begin
          beat_d = beat_q + BLOCK_WIDTH'(1);
          if (&beat_q) begin
            state_d = StDone;
            last_d  = owner_q;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  logic in_burst;
  logic in_done;

  assign in_burst   = (state_q == StBurst);
  assign in_done    = (state_q == StDone);

  assign o_mem_rd   = in_burst;
  assign o_mem_addr = base_q | {{(ADDR_WIDTH - BLOCK_WIDTH){1'b0}}, beat_q};
  assign o_busy     = in_burst | in_done;
  assign o_owner    = owner_q;

  assign o_m0_data  = i_mem_data;
  assign o_m1_data  = i_mem_data;
  assign o_m0_beat  = beat_q;
  assign o_m1_beat  = beat_q;
  assign o_m0_valid = in_burst & i_mem_ready & ~owner_q;
  assign o_m1_valid = in_burst & i_mem_ready & owner_q;
  assign o_m0_done  = in_done & ~owner_q;
  assign o_m1_done  = in_done & owner_q;

endmodule
